// File: rtl/darkriscv_dbus_bridge.sv
// Data-bus bridge between the darkriscv core and a word-only memory port.
// Byte/half stores become read-modify-write; loads return the selected lane zero-extended.
module darkriscv_dbus_bridge #(
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter logic [31:0] ERR_DATA       = 32'hFFFFFFFF
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] core_daddr,
  input  logic [31:0] core_datao,
  input  logic [2:0]  core_dlen,
  input  logic        core_drd,
  input  logic        core_dwr,
  output logic [31:0] core_datai,
  output logic        core_hlt,
  output logic        core_berr,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_address,
  output logic [31:0] mem_write_data,
  input  logic [31:0] mem_read_data,
  input  logic        mem_response
);

  localparam logic [2:0] StIdle  = 3'd0;
  localparam logic [2:0] StRd    = 3'd1;
  localparam logic [2:0] StRmwRd = 3'd2;
  localparam logic [2:0] StRmwWr = 3'd3;
  localparam logic [2:0] StWr    = 3'd4;
  localparam logic [2:0] StDone  = 3'd5;
  localparam logic [2:0] StErr   = 3'd6;

  localparam logic [1:0] SzByte = 2'd0;
  localparam logic [1:0] SzHalf = 2'd1;
  localparam logic [1:0] SzWord = 2'd2;

  localparam int unsigned CntW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 1);

  logic [2:0]      state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [1:0]      off_q, off_d;
  logic [1:0]      size_q, size_d;
  logic [15:0]     store_q, store_d;
  logic [31:0]     datai_q, datai_d;
  logic [31:0]     addr_q, addr_d;
  logic [31:0]     wdata_q, wdata_d;
  logic            mrd_q, mrd_d;
  logic            mwr_q, mwr_d;

  logic [1:0]  req_size;
  logic        req;
  logic        misaligned;
  logic        waiting;
  logic        timeout;
  logic        hlt;
  logic [31:0] rd_shift;
  logic [31:0] rd_lane;
  logic [31:0] merged;

  // Anything other than a clean byte/half code is handled as a word access.
  always_comb begin
    req_size = SzWord;
    if (core_dlen == 3'b001) begin
      req_size = SzByte;
    end else if (core_dlen == 3'b010) begin
      req_size = SzHalf;
    end
    req        = core_drd | core_dwr;
    misaligned = ((req_size == SzHalf) && core_daddr[0]) ||
                 ((req_size == SzWord) && (core_daddr[1:0] != 2'b00));
  end

  always_comb begin
    rd_shift = mem_read_data >> {off_q, 3'b000};
    case (size_q)
      SzByte:  rd_lane = {24'h0, rd_shift[7:0]};
      SzHalf:  rd_lane = {16'h0, rd_shift[15:0]};
      default: rd_lane = rd_shift;
    endcase
    merged = mem_read_data;
    if (size_q == SzByte) begin
      merged[{off_q, 3'b000} +: 8] = store_q[7:0];
    end else if (size_q == SzHalf) begin
      merged[{off_q[1], 4'b0000} +: 16] = store_q[15:0];
    end
  end

  assign waiting = (state_q == StRd) || (state_q == StRmwRd) ||
                   (state_q == StRmwWr) || (state_q == StWr);
  assign timeout = (cnt_q == CntLast);

  always_comb begin
    state_d = state_q;
    off_d   = off_q;
    size_d  = size_q;
    store_d = store_q;
    datai_d = datai_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    mrd_d   = mrd_q;
    mwr_d   = mwr_q;
    case (state_q)
      StIdle: begin
        if (req) begin
          off_d   = core_daddr[1:0];
          size_d  = req_size;
          store_d = core_datao[15:0];
          if (misaligned) begin
            state_d = StErr;
            if (!core_dwr) begin
              datai_d = ERR_DATA;
            end
          end else begin
            addr_d = {core_daddr[31:2], 2'b00};
            if (core_dwr && (req_size == SzWord)) begin
              state_d = StWr;
              mwr_d   = 1'b1;
              wdata_d = core_datao;
            end else if (core_dwr) begin
              state_d = StRmwRd;
              mrd_d   = 1'b1;
            end else begin
              state_d = StRd;
              mrd_d   = 1'b1;
            end
          end
        end
      end
      StRd: begin
        if (mem_response) begin
          state_d = StDone;
          mrd_d   = 1'b0;
          datai_d = rd_lane;
        end else if (timeout) begin
          state_d = StErr;
          mrd_d   = 1'b0;
          datai_d = ERR_DATA;
        end
      end
      StRmwRd: begin
        if (mem_response) begin
          state_d = StRmwWr;
          mrd_d   = 1'b0;
          mwr_d   = 1'b1;
          wdata_d = merged;
        end else if (timeout) begin
          state_d = StErr;
          mrd_d   = 1'b0;
        end
      end
      StRmwWr, StWr: begin
        if (mem_response) begin
          state_d = StDone;
          mwr_d   = 1'b0;
        end else if (timeout) begin
          state_d = StErr;
          mwr_d   = 1'b0;
        end
      end
      StDone, StErr: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
        mrd_d   = 1'b0;
        mwr_d   = 1'b0;
      end
    endcase

    // The wait counter restarts on every state entry.
    if (state_d != state_q) begin
      cnt_d = '0;
    end else if (waiting) begin
      cnt_d = cnt_q + 1'b1;
    end else begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      off_q   <= 2'b00;
      size_q  <= SzWord;
      store_q <= 16'h0;
      datai_q <= 32'h0;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
      mrd_q   <= 1'b0;
      mwr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      off_q   <= off_d;
      size_q  <= size_d;
      store_q <= store_d;
      datai_q <= datai_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      mrd_q   <= mrd_d;
      mwr_q   <= mwr_d;
    end
  end

  always_comb begin
    hlt = 1'b0;
    case (state_q)
      StRd, StRmwRd, StRmwWr, StWr: hlt = 1'b1;
      StIdle:                       hlt = req && !misaligned;
      default:                      hlt = 1'b0;
    endcase
  end

  // Stall is combinational, so gate it with reset to drop it while reset is held.
  assign core_hlt       = reset_n & hlt;
  assign core_berr      = (state_q == StErr);
  assign core_datai     = datai_q;
  assign mem_read       = mrd_q;
  assign mem_write      = mwr_q;
  assign mem_address    = addr_q;
  assign mem_write_data = wdata_q;

endmodule

// File: tb/tb_darkriscv_dbus_bridge.sv
// Bench for darkriscv_dbus_bridge: directed vector table, hand-written timeout/reset
// sequences and random accesses against a byte-level memory model.
module tb_darkriscv_dbus_bridge;

  localparam int unsigned TO = 16;
  localparam logic [31:0] ERRD = 32'hFFFFFFFF;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [31:0] core_daddr = '0;
  logic [31:0] core_datao = '0;
  logic [2:0]  core_dlen = 3'b100;
  logic        core_drd = 1'b0;
  logic        core_dwr = 1'b0;
  logic [31:0] core_datai;
  logic        core_hlt;
  logic        core_berr;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_address;
  logic [31:0] mem_write_data;
  logic [31:0] mem_read_data = '0;
  logic        mem_response = 1'b0;

  darkriscv_dbus_bridge #(
    .TIMEOUT_CYCLES(TO),
    .ERR_DATA      (ERRD)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .core_daddr    (core_daddr),
    .core_datao    (core_datao),
    .core_dlen     (core_dlen),
    .core_drd      (core_drd),
    .core_dwr      (core_dwr),
    .core_datai    (core_datai),
    .core_hlt      (core_hlt),
    .core_berr     (core_berr),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .mem_address   (mem_address),
    .mem_write_data(mem_write_data),
    .mem_read_data (mem_read_data),
    .mem_response  (mem_response)
  );

  always #5 clk = ~clk;

  // Memory responder: answers after lat strobe cycles; only this process writes mem.
  logic [31:0] mem [1024];
  int          lat = 1;
  logic        rd_en = 1'b1;
  logic        wr_en = 1'b1;
  int          wait_cnt = 0;
  int          n_rd = 0;
  int          n_wr = 0;
  logic        preset_req = 1'b0;
  logic [9:0]  preset_idx = '0;
  logic [31:0] preset_val = '0;

  always @(negedge clk) begin
    mem_response = 1'b0;
    if (preset_req) mem[preset_idx] = preset_val;
    if (!reset_n) begin
      wait_cnt = 0;
    end else if ((mem_read && rd_en) || (mem_write && wr_en)) begin
      wait_cnt++;
      if (wait_cnt >= lat) begin
        wait_cnt = 0;
        mem_response = 1'b1;
        if (mem_read) begin
          mem_read_data = mem[mem_address[11:2]];
          n_rd++;
        end else begin
          mem[mem_address[11:2]] = mem_write_data;
          n_wr++;
        end
      end
    end else begin
      wait_cnt = 0;
    end
  end

  int total = 0;
  int bad = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic preset(input logic [31:0] addr, input logic [31:0] val);
    @(negedge clk);
    #1;
    preset_idx = addr[11:2];
    preset_val = val;
    preset_req = 1'b1;
    @(negedge clk);
    #1;
    preset_req = 1'b0;
  endtask

  // Drives one core access and holds it until the DONE/ERR cycle.
  task automatic access(input logic wr, input logic rd, input logic [31:0] addr,
                        input logic [2:0] dlen, input logic [31:0] data,
                        output int hlt_n, output int rds, output int wrs,
                        output logic berr_seen, output logic [31:0] datai,
                        output logic addr_ok);
    logic prev_hlt;
    logic finished;
    hlt_n = 0; rds = 0; wrs = 0; berr_seen = 1'b0; datai = '0; addr_ok = 1'b1;
    prev_hlt = 1'b0; finished = 1'b0;
    @(negedge clk);
    core_drd = rd; core_dwr = wr; core_daddr = addr; core_dlen = dlen; core_datao = data;
    for (int c = 0; c < 100 && !finished; c++) begin
      #1;
      if (core_hlt) hlt_n++;
      if (mem_read) rds++;
      if (mem_write) wrs++;
      if ((mem_read || mem_write) && (mem_address !== {addr[31:2], 2'b00})) addr_ok = 1'b0;
      if (core_berr) berr_seen = 1'b1;
      if (core_berr || (prev_hlt && !core_hlt)) begin
        finished = 1'b1;
        datai = core_datai;
        core_drd = 1'b0;
        core_dwr = 1'b0;
      end else begin
        prev_hlt = core_hlt;
        @(negedge clk);
      end
    end
    total++;
    if (!finished) begin
      bad++;
      $display("FAIL access_end: got no completion within 100 cycles required completion");
      core_drd = 1'b0;
      core_dwr = 1'b0;
    end
  endtask

  typedef struct {
    logic        wr;
    logic        rd;
    logic [31:0] addr;
    logic [2:0]  dlen;
    logic [31:0] data;
    int          lat;
    logic [31:0] old;
    logic [31:0] e_datai;
    logic        e_berr;
    int          e_hlt;
    int          e_rd;
    int          e_wr;
    logic [31:0] e_mem;
  } vec_t;

  vec_t vecs[12];
  logic [31:0] model_mem [64];

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int hn, rs, ws, r0, w0;
    logic be, aok;
    logic [31:0] di;
    logic [31:0] cur_datai;

    vecs[0]  = '{1'b0, 1'b1, 32'h100, 3'b100, 32'h0,        3, 32'hDEADBEEF,
                 32'hDEADBEEF, 1'b0, 4, 1, 0, 32'hDEADBEEF};
    vecs[1]  = '{1'b0, 1'b1, 32'h103, 3'b001, 32'h0,        1, 32'h11223344,
                 32'h00000011, 1'b0, 2, 1, 0, 32'h11223344};
    vecs[2]  = '{1'b1, 1'b0, 32'h202, 3'b010, 32'h0000ABCD, 2, 32'h55667788,
                 32'h00000011, 1'b0, 5, 1, 1, 32'hABCD7788};
    vecs[3]  = '{1'b0, 1'b1, 32'h101, 3'b010, 32'h0,        1, 32'hDEADBEEF,
                 32'hFFFFFFFF, 1'b1, 0, 0, 0, 32'hDEADBEEF};
    vecs[4]  = '{1'b1, 1'b0, 32'h301, 3'b001, 32'h0000005A, 1, 32'h01020304,
                 32'hFFFFFFFF, 1'b0, 3, 1, 1, 32'h01025A04};
    vecs[5]  = '{1'b0, 1'b1, 32'h302, 3'b010, 32'h0,        2, 32'hA1B2C3D4,
                 32'h0000A1B2, 1'b0, 3, 1, 0, 32'hA1B2C3D4};
    vecs[6]  = '{1'b1, 1'b0, 32'h304, 3'b100, 32'h12345678, 1, 32'h0,
                 32'h0000A1B2, 1'b0, 2, 0, 1, 32'h12345678};
    vecs[7]  = '{1'b0, 1'b1, 32'h308, 3'b011, 32'h0,        1, 32'hCAFEF00D,
                 32'hCAFEF00D, 1'b0, 2, 1, 0, 32'hCAFEF00D};
    vecs[8]  = '{1'b1, 1'b0, 32'h30A, 3'b100, 32'hFFFFFFFF, 1, 32'h0BADBEEF,
                 32'hCAFEF00D, 1'b1, 0, 0, 0, 32'h0BADBEEF};
    vecs[9]  = '{1'b0, 1'b1, 32'h30E, 3'b001, 32'h0,        1, 32'h87654321,
                 32'h00000065, 1'b0, 2, 1, 0, 32'h87654321};
    vecs[10] = '{1'b1, 1'b0, 32'h30C, 3'b010, 32'hFFFF1234, 1, 32'h87654321,
                 32'h00000065, 1'b0, 3, 1, 1, 32'h87651234};
    vecs[11] = '{1'b1, 1'b1, 32'h310, 3'b100, 32'h0F0F0F0F, 2, 32'h0,
                 32'h00000065, 1'b0, 3, 0, 1, 32'h0F0F0F0F};

    // Reset state
    repeat (3) @(negedge clk);
    #1;
    chk("rst_datai", core_datai, 32'h0);
    chk("rst_hlt", {31'h0, core_hlt}, 32'h0);
    chk("rst_berr", {31'h0, core_berr}, 32'h0);
    chk("rst_strobes", {30'h0, mem_read, mem_write}, 32'h0);
    chk("rst_addr", mem_address, 32'h0);
    chk("rst_wdata", mem_write_data, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;

    // Directed vector table
    for (int i = 0; i < 12; i++) begin
      preset(vecs[i].addr, vecs[i].old);
      lat = vecs[i].lat;
      r0 = n_rd; w0 = n_wr;
      access(vecs[i].wr, vecs[i].rd, vecs[i].addr, vecs[i].dlen, vecs[i].data,
             hn, rs, ws, be, di, aok);
      chk($sformatf("v%0d_datai", i), di, vecs[i].e_datai);
      chk($sformatf("v%0d_berr", i), {31'h0, be}, {31'h0, vecs[i].e_berr});
      chk($sformatf("v%0d_hlt", i), hn, vecs[i].e_hlt);
      chk($sformatf("v%0d_reads", i), n_rd - r0, vecs[i].e_rd);
      chk($sformatf("v%0d_writes", i), n_wr - w0, vecs[i].e_wr);
      chk($sformatf("v%0d_addr", i), {31'h0, aok}, 32'h1);
      @(negedge clk);
      chk($sformatf("v%0d_mem", i), mem[vecs[i].addr[11:2]], vecs[i].e_mem);
    end

    // Word store timeout: strobe held for TO cycles, then a berr pulse
    preset(32'h400, 32'h77777777);
    rd_en = 1'b0; wr_en = 1'b0;
    access(1'b1, 1'b0, 32'h400, 3'b100, 32'h12345678, hn, rs, ws, be, di, aok);
    chk("to_wr_strobe", ws, TO);
    chk("to_wr_berr", {31'h0, be}, 32'h1);
    chk("to_wr_hlt", hn, TO + 1);
    chk("to_wr_datai", di, 32'h00000065);
    @(negedge clk);
    #1;
    chk("to_after", {29'h0, core_berr, core_hlt, mem_write}, 32'h0);
    chk("to_wr_mem", mem[10'h100], 32'h77777777);
    access(1'b0, 1'b1, 32'h402, 3'b010, 32'h0, hn, rs, ws, be, di, aok);
    chk("to_rd_strobe", rs, TO);
    chk("to_rd_datai", di, ERRD);
    chk("to_rd_berr", {31'h0, be}, 32'h1);
    rd_en = 1'b1; wr_en = 1'b1;

    // Randomized accesses against a byte-lane model
    for (int w = 0; w < 64; w++) begin
      model_mem[w] = $urandom;
      preset(32'(w * 4), model_mem[w]);
    end
    cur_datai = di;
    for (int t = 0; t < 200; t++) begin
      logic        wr, rd, mis;
      logic [31:0] addr, data, e_datai;
      logic [2:0]  dlen;
      logic [63:0] wide;
      int          sz, off, idx, e_hlt, e_rd, e_wr;
      idx  = $urandom_range(0, 63);
      off  = $urandom_range(0, 3);
      addr = 32'(idx * 4 + off);
      wr   = $urandom_range(0, 1) == 1;
      rd   = wr ? ($urandom_range(0, 1) == 1) : 1'b1;
      data = $urandom;
      case ($urandom_range(0, 5))
        0:       dlen = 3'b001;
        1:       dlen = 3'b010;
        2, 3:    dlen = 3'b100;
        4:       dlen = 3'b000;
        default: dlen = 3'b110;
      endcase
      lat = $urandom_range(1, 3);
      sz  = (dlen == 3'b001) ? 1 : (dlen == 3'b010) ? 2 : 4;
      mis = (off % sz) != 0;
      e_hlt = 0; e_rd = 0; e_wr = 0;
      if (mis) begin
        if (!wr) cur_datai = ERRD;
      end else if (!wr) begin
        wide = {32'h0, model_mem[idx]} >> (8 * off);
        wide = wide & ((64'd1 << (8 * sz)) - 64'd1);
        cur_datai = wide[31:0];
        e_rd = 1; e_hlt = 1 + lat;
      end else if (sz == 4) begin
        model_mem[idx] = data;
        e_wr = 1; e_hlt = 1 + lat;
      end else begin
        for (int b = 0; b < sz; b++) model_mem[idx][8 * (off + b) +: 8] = data[8 * b +: 8];
        e_rd = 1; e_wr = 1; e_hlt = 1 + 2 * lat;
      end
      e_datai = cur_datai;
      r0 = n_rd; w0 = n_wr;
      access(wr, rd, addr, dlen, data, hn, rs, ws, be, di, aok);
      chk($sformatf("r%0d_datai", t), di, e_datai);
      chk($sformatf("r%0d_berr", t), {31'h0, be}, {31'h0, mis});
      chk($sformatf("r%0d_hlt", t), hn, e_hlt);
      chk($sformatf("r%0d_rw", t), {n_rd - r0, n_wr - w0} , {e_rd, e_wr});
      chk($sformatf("r%0d_addr", t), {31'h0, aok}, 32'h1);
    end
    @(negedge clk);
    begin
      int diffs = 0;
      for (int w = 0; w < 64; w++) if (mem[w] !== model_mem[w]) diffs++;
      chk("rand_mem_words", diffs, 0);
    end

    // Reset while the RMW write phase is waiting for its response
    preset(32'h500, 32'h11111111);
    lat = 1; wr_en = 1'b0;
    begin
      logic seen = 1'b0;
      int   stray = 0;
      @(negedge clk);
      core_dwr = 1'b1; core_daddr = 32'h501; core_dlen = 3'b001; core_datao = 32'hAA;
      for (int c = 0; c < 20 && !seen; c++) begin
        @(negedge clk);
        #1;
        seen = mem_write;
      end
      chk("rstmid_reached_wr", {31'h0, seen}, 32'h1);
      #2;
      reset_n = 1'b0;
      #1;
      chk("rstmid_strobes", {30'h0, mem_read, mem_write}, 32'h0);
      chk("rstmid_hlt", {31'h0, core_hlt}, 32'h0);
      chk("rstmid_addr", mem_address, 32'h0);
      chk("rstmid_datai", core_datai, 32'h0);
      core_dwr = 1'b0;
      wr_en = 1'b1;
      @(negedge clk);
      reset_n = 1'b1;
      for (int c = 0; c < 5; c++) begin
        @(negedge clk);
        #1;
        if (mem_read || mem_write || core_hlt || core_berr) stray++;
      end
      chk("rstmid_stray", stray, 0);
      chk("rstmid_mem", mem[10'h140], 32'h11111111);
    end
    access(1'b0, 1'b1, 32'h500, 3'b100, 32'h0, hn, rs, ws, be, di, aok);
    chk("post_rst_datai", di, 32'h11111111);
    chk("post_rst_hlt", hn, 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/darkriscv_dbus_bridge.md
Name: darkriscv_dbus_bridge

Overview:
- Sits between the darkriscv core data port and the Controller's data-memory port.
- Converts sub-word core accesses (byte and halfword, by DLEN) into word-only memory transactions.
- Sub-word writes use read-modify-write; loads return lane-extracted data.
- Stalls the core through HLT while a transaction is in flight and reports misalignment or timeout through BERR.

Parameters:
- TIMEOUT_CYCLES, 1024, maximum cycles to wait for mem_response per memory phase before aborting.
- ERR_DATA, 32'hFFFFFFFF, value driven on core_datai after an aborted read.

Ports:
- clk  input  1  system clock; single clock domain.
- reset_n  input  1  asynchronous, active-low reset.
- core_daddr  input  32  byte address from the core (DADDR).
- core_datao  input  32  store data, right-aligned (DATAO).
- core_dlen  input  3  access size: 3'b001 byte, 3'b010 half, 3'b100 word (DLEN).
- core_drd  input  1  load request (DRD).
- core_dwr  input  1  store request (DWR).
- core_datai  output  32  load data, right-aligned, zero-extended (DATAI).
- core_hlt  output  1  stall to the core (HLT).
- core_berr  output  1  one-cycle bus error pulse (BERR).
- mem_read  output  1  word read strobe to the Controller.
- mem_write  output  1  word write strobe to the Controller.
- mem_address  output  32  word-aligned address, bits [1:0] = 0.
- mem_write_data  output  32  full write word.
- mem_read_data  input  32  read word from the Controller.
- mem_response  input  1  one-cycle completion for the current read or write.

Behaviour:
- Reset (reset_n low, asynchronous):
  - state = IDLE, timeout counter = 0.
  - core_datai, mem_address, mem_write_data = 0.
  - core_hlt, core_berr, mem_read, mem_write = 0.
- core_hlt is combinational: high when state is RD, RMW_RD, RMW_WR or WR; also high in IDLE when drd or dwr is high and the access is aligned. Low in DONE and ERR.
- States and transitions:
  - IDLE, drd: latch address, dlen and byte offset; go to RD.
  - IDLE, dwr with dlen = word: go to WR.
  - IDLE, dwr with byte or half: go to RMW_RD.
  - IDLE, drd and dwr both high: treated as a write.
  - IDLE, dlen not one-hot: treated as a word access.
  - Alignment check in IDLE: half with addr[0] = 1, or word with addr[1:0] != 0, goes to ERR; no memory access is issued.
  - RD, RMW_RD: mem_read = 1 until mem_response.
    - RD then goes to DONE and latches core_datai = word >> (8 × offset), masked to 8, 16 or 32 bits.
    - RMW_RD then merges the store lane into the read word and goes to RMW_WR.
  - RMW_WR, WR: mem_write = 1 with the merged or full word until mem_response, then DONE.
  - DONE: one cycle, core_hlt = 0, core_datai valid; request inputs ignored; next state IDLE.
  - ERR: one cycle, core_berr = 1, core_hlt = 0; core_datai = ERR_DATA if the access was a read; next state IDLE.
- Timeout:
  - Counter resets on every state entry and increments while waiting for mem_response.
  - Reaching TIMEOUT_CYCLES - 1 with no response goes to ERR, and mem_read/mem_write drop in that cycle.
- mem_response arriving in IDLE, DONE or ERR is ignored.
- mem_address, mem_write_data and the strobes are registered and stay stable for the whole wait.
- core_datai holds its last value until the next read completion or error.
- Mid-transaction reset:
  - All outputs return to reset values immediately.
  - A partial RMW is not completed; the memory word keeps its pre-write value if RMW_WR was not reached.

Test Plan:
- Word load at 0x100, memory word 0xDEADBEEF, response 3 cycles after mem_read → hlt high 4 cycles; DONE cycle core_datai = 0xDEADBEEF; mem_address = 0x100.
- Byte load at 0x103, word 0x11223344 → mem_address = 0x100; core_datai = 0x00000011.
- Half store 0xABCD at 0x202, old word 0x55667788 → one read at 0x200, then write 0xABCD7788; hlt released in DONE.
- Half load at 0x101 → no mem_read issued; core_berr pulses 1 cycle; core_datai = 0xFFFFFFFF; hlt low the cycle after the request.
- Word store, no mem_response, TIMEOUT_CYCLES = 16 → mem_write high 16 cycles, then core_berr pulse, then IDLE.
- reset_n low during RMW_WR (mem_write high) → mem_write = 0 and core_hlt = 0 asynchronously; after release, state IDLE and no stray strobe.
